sd_cmd_rx: RTL
==============

# sd_cmd_rx

Receives SD-bus command responses on the CMD line. It sits directly downstream of the SD host command sequencer: the sequencer arms it after the last command bit and releases CMD to input. The block then hunts for the start bit, shifts in a 48-bit (R1/R3/R6/R7) or 136-bit (R2) frame, checks CRC7, end bit and timeout, and returns the raw frame with status flags. Sampling is paced by the sequencer's SDCLK rising-edge strobe, so the block needs no knowledge of the SDCLK divider.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64: number of SDCLK rising strobes to wait for a start bit before declaring timeout (NCR limit).

Ports:
- clk_i  input  1  system clock; all logic is on its rising edge.
- rst_i  input  1  reset, asynchronous and active-high.
- sdclk_rise_i  input  1  one-clk_i-cycle strobe marking the SDCLK rising edge (the sample point).
- cmd_i  input  1  CMD line input from the IOBUF.
- start_i  input  1  one-cycle arm pulse; ignored while busy_o=1.
- long_i  input  1  captured with start_i: 1 = 136-bit R2, 0 = 48-bit.
- crc_chk_i  input  1  captured with start_i: 0 disables the CRC check (R3).
- busy_o  output  1  high from the cycle after the accepted start_i until done_o.
- done_o  output  1  one-cycle completion pulse (success, error or timeout).
- timeout_o  output  1  status: no start bit arrived within TIMEOUT_CYCLES.
- crc_err_o  output  1  status: received CRC7 does not match the computed CRC7.
- end_err_o  output  1  status: end bit sampled as 0.
- resp_o  output  136  raw frame, right-aligned; a 48-bit frame occupies [47:0] and [135:48] is 0.

## Operation
- States: IDLE, WAIT_START, RECV, DONE.
- IDLE: on start_i, latch long_i and crc_chk_i; clear resp_o, the status flags, the timeout counter, the bit counter and the CRC; go to WAIT_START.
- WAIT_START: on each sdclk_rise_i:
  - if cmd_i=0, shift 0 into resp_o, set bit count to 1 and go to RECV;
  - otherwise increment the timeout counter; when the counter reaches TIMEOUT_CYCLES, set timeout_o and go to DONE.
- RECV: on each sdclk_rise_i, shift cmd_i into resp_o LSB-first-in (MSB of the frame ends at the top) and increment the bit count. The frame ends at count 48 or 136, then the block goes to DONE.
- CRC7: polynomial x^7+x^3+1, zero initial value.
  - 48-bit frames: covers frame bits 47..8 (start bit included).
  - 136-bit frames: covers bits 127..8; start bit, transmission bit and the 6 reserved bits are excluded.
  - On the last bit, compare the computed CRC with frame bits 7..1. crc_err_o = crc_chk_i && mismatch.
- end_err_o = (frame bit 0 == 0). It is not set on timeout.
- DONE: assert done_o for one cycle, then go to IDLE.
- busy_o is low in IDLE and in the cycle done_o is high.
- resp_o and all status flags hold their values until the next accepted start_i.

## Timing
- Reset values: busy_o=0, done_o=0, timeout_o=0, crc_err_o=0, end_err_o=0, resp_o=0, state=IDLE.
- Latency: done_o is high exactly 1 clk_i after the clk_i edge that samples the final bit, or that hits the timeout.
- start_i coincident with sdclk_rise_i: the arm is accepted, and that strobe is neither sampled nor counted.
- start_i while busy_o=1 is ignored.
- The timeout counter is $clog2(TIMEOUT_CYCLES+1) bits, with no wrap.
- The bit counter is 8 bits and compared against 48 or 136.
- rst_i asserted mid-frame aborts immediately to reset values; no done_o is issued.
- cmd_i is already synchronised by the sequencer's IOB register; this block adds no synchroniser.

## Configuration
- SD_CMD_RX_CRC_EN defined: the CRC7 checker is instantiated and crc_err_o behaves as described above.
- SD_CMD_RX_CRC_EN undefined: no CRC logic is built, crc_err_o is tied to 0, and crc_chk_i is ignored. Frame capture, end-bit check and timeout are unchanged.

## Structure
- Package sd_pkg holds:
  - the state enum;
  - SD_RESP_SHORT_LEN=48 and SD_RESP_LONG_LEN=136;
  - SD_CRC7_POLY=7'h09;
  - the R2 CRC-window bounds (127..8).
- Sub-module sd_crc7: serial CRC7 with clr_i, en_i and d_i inputs and a crc_o output. It is shared with the command transmitter.

## Test plan
- R7 echo: arm short with crc_chk=1, idle CMD high for 5 strobes, then frame 0x08_000001AA_13 → done_o; resp_o[47:0]=0x08000001AA13; all flags 0.
- CRC error: the same frame with arg 0x000001AB → crc_err_o=1, end_err_o=0, timeout_o=0.
- R3: arm short with crc_chk=0, frame 0x3F_00FF8000_FF → crc_err_o=0; resp_o[39:8]=0x00FF8000.
- R2: arm long, frame 0x3F followed by 15 zero bytes and 0x01 (CRC of zero content is 0) → resp_o=136'h3F000…0001; flags 0.
- Timeout: arm short with CMD held high → done_o exactly on the 64th strobe plus 1 clk_i; timeout_o=1; resp_o=0.
- Reset mid-frame and re-arm: rst_i after 20 bits → all outputs 0 and no done_o; a re-armed R7 frame then completes cleanly.

Source files
------------

// File: rtl/sd_pkg.sv
// Shared types and constants for the SD command-line receiver and CRC7 helper.
package sd_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitStart,
    StRecv,
    StDone
  } sd_rx_state_e;

  localparam int unsigned SD_RESP_SHORT_LEN = 48;
  localparam int unsigned SD_RESP_LONG_LEN  = 136;
  localparam logic [6:0]  SD_CRC7_POLY      = 7'h09;

  // CRC window, frame-bit indices inclusive (R2 skips start, transmission and reserved bits)
  localparam int unsigned SD_R2_CRC_HI    = 127;
  localparam int unsigned SD_R2_CRC_LO    = 8;
  localparam int unsigned SD_SHORT_CRC_HI = 47;

  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc, input logic d);
    logic fb;
    fb = d ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 (x^7+x^3+1, zero seed), one bit per enabled cycle; shared with the command TX.
module sd_crc7
  import sd_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       en_i,
  input  logic       d_i,
  output logic [6:0] crc_o
);

  logic [6:0] r_crc;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crc <= 7'h00;
    end else if (clr_i) begin
      r_crc <= 7'h00;
    end else if (en_i) begin
      r_crc <= sd_crc7_step(r_crc, d_i);
    end
  end

  assign crc_o = r_crc;

endmodule

// File: rtl/sd_cmd_rx.sv
// SD CMD-line response receiver: start-bit hunt, 48/136-bit capture, CRC7/end-bit/timeout status.
// Optional CRC7 checking is built only when SD_CMD_RX_CRC_EN is defined.
module sd_cmd_rx
  import sd_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         sdclk_rise_i,
  input  logic         cmd_i,
  input  logic         start_i,
  input  logic         long_i,
  input  logic         crc_chk_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         timeout_o,
  output logic         crc_err_o,
  output logic         end_err_o,
  output logic [135:0] resp_o
);

  localparam int unsigned    ToW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ToW-1:0] ToMax    = ToW'(TIMEOUT_CYCLES);
  localparam logic [7:0]     LenShort = 8'(SD_RESP_SHORT_LEN);
  localparam logic [7:0]     LenLong  = 8'(SD_RESP_LONG_LEN);

  sd_rx_state_e   r_state, w_state_nxt;
  logic           r_long, w_long_nxt;
  logic [135:0]   r_resp, w_resp_nxt;
  logic [7:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [ToW-1:0] r_to_cnt, w_to_cnt_nxt, w_to_inc;
  logic           r_timeout, w_timeout_nxt;
  logic           r_end_err, w_end_err_nxt;
  logic           w_start_acc, w_frame_end;
  logic [7:0]     w_len;

  assign w_len       = r_long ? LenLong : LenShort;
  assign w_start_acc = (r_state == StIdle) && start_i;
  assign w_to_inc    = r_to_cnt + 1'b1;

  always_comb begin
    w_state_nxt   = r_state;
    w_long_nxt    = r_long;
    w_resp_nxt    = r_resp;
    w_bit_cnt_nxt = r_bit_cnt;
    w_to_cnt_nxt  = r_to_cnt;
    w_timeout_nxt = r_timeout;
    w_end_err_nxt = r_end_err;
    w_frame_end   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_i) begin
          w_state_nxt   = StWaitStart;
          w_long_nxt    = long_i;
          w_resp_nxt    = '0;
          w_bit_cnt_nxt = '0;
          w_to_cnt_nxt  = '0;
          w_timeout_nxt = 1'b0;
          w_end_err_nxt = 1'b0;
        end
      end
      StWaitStart: begin
        if (sdclk_rise_i) begin
          if (!cmd_i) begin
            w_resp_nxt    = {r_resp[134:0], 1'b0};
            w_bit_cnt_nxt = 8'd1;
            w_state_nxt   = StRecv;
          end else begin
            w_to_cnt_nxt = w_to_inc;
            if (w_to_inc == ToMax) begin
              w_timeout_nxt = 1'b1;
              w_state_nxt   = StDone;
            end
          end
        end
      end
      StRecv: begin
        if (sdclk_rise_i) begin
          w_resp_nxt    = {r_resp[134:0], cmd_i};
          w_bit_cnt_nxt = r_bit_cnt + 8'd1;
          if (r_bit_cnt == w_len - 8'd1) begin
            w_end_err_nxt = !cmd_i;
            w_frame_end   = 1'b1;
            w_state_nxt   = StDone;
          end
        end
      end
      StDone: w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= StIdle;
      r_long    <= 1'b0;
      r_resp    <= '0;
      r_bit_cnt <= '0;
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
      r_end_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_long    <= w_long_nxt;
      r_resp    <= w_resp_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_to_cnt  <= w_to_cnt_nxt;
      r_timeout <= w_timeout_nxt;
      r_end_err <= w_end_err_nxt;
    end
  end

`ifdef SD_CMD_RX_CRC_EN
  logic       r_crc_chk, r_crc_err, w_sample, w_crc_en;
  logic [6:0] w_crc;
  logic [7:0] w_idx, w_crc_hi;

  // Frame-bit index of the bit being sampled this strobe
  assign w_sample = sdclk_rise_i &&
                    (((r_state == StWaitStart) && !cmd_i) || (r_state == StRecv));
  assign w_idx    = w_len - 8'd1 - r_bit_cnt;
  assign w_crc_hi = r_long ? 8'(SD_R2_CRC_HI) : 8'(SD_SHORT_CRC_HI);
  assign w_crc_en = w_sample && (w_idx <= w_crc_hi) && (w_idx >= 8'(SD_R2_CRC_LO));

  sd_crc7 u_crc7 (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .clr_i (w_start_acc),
    .en_i  (w_crc_en),
    .d_i   (cmd_i),
    .crc_o (w_crc)
  );

  // On the end bit, r_resp[6:0] still holds frame bits 7..1 (the received CRC)
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_crc_chk <= 1'b0;
      r_crc_err <= 1'b0;
    end else if (w_start_acc) begin
      r_crc_chk <= crc_chk_i;
      r_crc_err <= 1'b0;
    end else if (w_frame_end) begin
      r_crc_err <= r_crc_chk && (w_crc != r_resp[6:0]);
    end
  end

  assign crc_err_o = r_crc_err;
`else
  logic w_unused_crc_chk;
  assign w_unused_crc_chk = crc_chk_i;
  assign crc_err_o        = 1'b0;
`endif

  assign busy_o    = (r_state == StWaitStart) || (r_state == StRecv);
  assign done_o    = (r_state == StDone);
  assign timeout_o = r_timeout;
  assign end_err_o = r_end_err;
  assign resp_o    = r_resp;

endmodule
